// File: rtl/bw_dispatcher_v2.sv
// rtl/bw_dispatcher_v2.sv - burst dispatcher with G x G broadcast expansion; optional DISPATCH_PERF_CNT_EN counters
module bw_dispatcher_v2 #(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 8,
    parameter int G      = 4,
    parameter int LEN_W  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [AW-1:0]     w_write_address,
    input  logic [AW-1:0]     a_write_address,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic              start,
    input  logic [AW-1:0]     w_base,
    input  logic [AW-1:0]     a_base,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [1:0]        a_mode,
    input  logic [1:0]        w_mode,
    input  logic              out_ready,
    output logic [DATA_W-1:0] activations,
    output logic [DATA_W-1:0] weight_columns,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              empty
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       beats_sent
`endif
);

    localparam int CW = DATA_W / (G * G);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] w_buf [DEPTH];
    logic [DATA_W-1:0] a_buf [DEPTH];
    logic [AW-1:0]     w_ptr, a_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        a_mode_q, w_mode_q;
    logic              s1_valid, s1_last;
    logic [DATA_W-1:0] s1_w, s1_a;
    logic              start_acc, fetch, s1_adv, accept;

    // Mode 10 repeats the low DATA_W/G bits, i.e. output chunk k takes chunk k mod G.
    function automatic logic [DATA_W-1:0] expand(input logic [DATA_W-1:0] d, input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = d;
        for (int k = 0; k < G * G; k++) begin
            case (m)
                2'b01:   r[k*CW +: CW] = d[(k / G)*CW +: CW];
                2'b10:   r[k*CW +: CW] = d[(k % G)*CW +: CW];
                2'b11:   r[k*CW +: CW] = d[0 +: CW];
                default: r[k*CW +: CW] = d[k*CW +: CW];
            endcase
        end
        return r;
    endfunction

    assign s1_adv = !out_valid || out_ready;
    assign accept = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    if (fetch && remaining == LEN_W'(1)) state_nx = DRAIN;
            DRAIN:   if (accept && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        start_acc = (state == IDLE) && start;
        fetch     = (state == READ) && (!s1_valid || s1_adv);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_buf[i] <= '0;
                a_buf[i] <= '0;
            end
            empty <= 1'b1;
        end else if (wen) begin
            w_buf[w_write_address] <= w_in;
            a_buf[a_write_address] <= a_in;
            empty                  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr     <= '0;
            a_ptr     <= '0;
            remaining <= '0;
            a_mode_q  <= '0;
            w_mode_q  <= '0;
        end else if (start_acc) begin
            w_ptr     <= w_base;
            a_ptr     <= a_base;
            remaining <= (burst_len == '0) ? LEN_W'(1) : burst_len;
            a_mode_q  <= a_mode;
            w_mode_q  <= w_mode;
        end else if (fetch) begin
            w_ptr     <= w_ptr + AW'(1);
            a_ptr     <= a_ptr + AW'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Stage 1 reads with registered semantics, so a same-edge write is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_w     <= '0;
            s1_a     <= '0;
        end else if (fetch) begin
            s1_valid <= 1'b1;
            s1_last  <= (remaining == LEN_W'(1));
            s1_w     <= w_buf[w_ptr];
            s1_a     <= a_buf[a_ptr];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            activations    <= '0;
            weight_columns <= '0;
            done           <= 1'b0;
        end else begin
            done <= (state == DRAIN) && accept && out_last;
            if (s1_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_last       <= s1_last;
                    activations    <= expand(s1_a, a_mode_q);
                    weight_columns <= expand(s1_w, w_mode_q);
                end
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            beats_sent   <= '0;
        end else if (start_acc) begin
            stall_cycles <= '0;
            beats_sent   <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (accept && beats_sent != '1)                    beats_sent   <= beats_sent + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bw_dispatcher_v2.sv
// tb/tb_bw_dispatcher_v2.sv - randomized scoreboard bench for bw_dispatcher_v2
module tb_bw_dispatcher_v2;

    localparam int DATA_W = 1024;
    localparam int DEPTH  = 8;
    localparam int G      = 4;
    localparam int LEN_W  = 8;
    localparam int AW     = 3;
    localparam int CW     = DATA_W / (G * G);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wen;
    logic [AW-1:0]     w_write_address, a_write_address;
    logic [DATA_W-1:0] w_in, a_in;
    logic              start;
    logic [AW-1:0]     w_base, a_base;
    logic [LEN_W-1:0]  burst_len;
    logic [1:0]        a_mode, w_mode;
    logic              out_ready;
    logic [DATA_W-1:0] activations, weight_columns;
    logic              out_valid, out_last, busy, done, empty;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0]       stall_cycles, beats_sent;
`endif

    bw_dispatcher_v2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .G(G), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen),
        .w_write_address(w_write_address), .a_write_address(a_write_address),
        .w_in(w_in), .a_in(a_in), .start(start), .w_base(w_base), .a_base(a_base),
        .burst_len(burst_len), .a_mode(a_mode), .w_mode(w_mode), .out_ready(out_ready),
        .activations(activations), .weight_columns(weight_columns),
        .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done), .empty(empty)
`ifdef DISPATCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .beats_sent(beats_sent)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] w;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] wmem [DEPTH];
    logic [DATA_W-1:0] amem [DEPTH];
    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, acc_cnt = 0, stall_cnt = 0;
    bit lat_pend = 0, done_seen = 0, exp_done = 0, hold_pend = 0;
    logic [DATA_W-1:0] h_a, h_w;
    logic              h_last;

    always @(posedge clk) cyc++;

    // Reference expansion built as an ordered list of chunks, LSB first.
    function automatic logic [DATA_W-1:0] ref_expand(input logic [DATA_W-1:0] d, input logic [1:0] m);
        logic [CW-1:0]     ch[$];
        logic [CW-1:0]     src[G*G];
        logic [DATA_W-1:0] res;
        for (int k = 0; k < G * G; k++) src[k] = d[k*CW +: CW];
        if (m == 2'b00) return d;
        if (m == 2'b01) for (int i = 0; i < G; i++) for (int j = 0; j < G; j++) ch.push_back(src[i]);
        if (m == 2'b10) for (int rep = 0; rep < G; rep++) for (int i = 0; i < G; i++) ch.push_back(src[i]);
        if (m == 2'b11) for (int k = 0; k < G * G; k++) ch.push_back(src[0]);
        res = '0;
        for (int k = 0; k < G * G; k++) res[k*CW +: CW] = ch[k];
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_word(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            int k;
            k = 0;
            while (k < G * G - 1 && act[k*CW +: CW] === exp[k*CW +: CW]) k++;
            errors++;
            $display("FAIL %s chunk %0d got %h want %h (cycle %0d)", name, k, act[k*CW +: CW], exp[k*CW +: CW], cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
            exp_done  = 0;
            lat_pend  = 0;
        end else begin
            if (hold_pend) begin
                chk_bit("hold_valid", out_valid, 1'b1);
                chk_word("hold_act", activations, h_a);
                chk_word("hold_w", weight_columns, h_w);
                chk_bit("hold_last", out_last, h_last);
            end
            hold_pend = out_valid && !out_ready;
            h_a = activations; h_w = weight_columns; h_last = out_last;
            if (out_valid) begin
                if (lat_pend) begin
                    chk_int("first_beat_latency", cyc - start_cyc, 2);
                    lat_pend = 0;
                end
                if (!out_ready) stall_cnt++;
                else if (exp_q.size() == 0) begin
                    chk_bit("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk_word("beat_act", activations, e.a);
                    chk_word("beat_w", weight_columns, e.w);
                    chk_bit("beat_last", out_last, e.last);
                    acc_cnt++;
                end
            end
            chk_bit("done", done, exp_done);
            if (done) done_seen = 1;
            exp_done = out_valid && out_ready && out_last;
        end
    end

    task automatic push_exp(input int wb, input int ab, input int len, input logic [1:0] am, input logic [1:0] wm);
        int n;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.a    = ref_expand(amem[(ab + i) % DEPTH], am);
            b.w    = ref_expand(wmem[(wb + i) % DEPTH], wm);
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wr(input int idx, input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] ad);
        wen = 1; w_write_address = AW'(idx); a_write_address = AW'(idx); w_in = wd; a_in = ad;
        @(posedge clk); #1;
        wen = 0;
        wmem[idx] = wd; amem[idx] = ad;
    endtask

    task automatic launch(input int wb, input int ab, input int len, input logic [1:0] am, input logic [1:0] wm);
        start = 1; w_base = AW'(wb); a_base = AW'(ab); burst_len = LEN_W'(len); a_mode = am; w_mode = wm;
        start_cyc = cyc + 1; lat_pend = 1; done_seen = 0; stall_cnt = 0; acc_cnt = 0;
        @(posedge clk); #1;
        start = 0;
    endtask

    // inject: 1 = start while busy, 2 = write index 2 on the edge it is fetched
    task automatic do_burst(input int wb, input int ab, input int len, input logic [1:0] am,
                            input logic [1:0] wm, input int rmode, input int inject);
        int t, n;
        n = (len == 0) ? 1 : len;
        push_exp(wb, ab, len, am, wm);
        out_ready = 1;
        launch(wb, ab, len, am, wm);
        t = 0;
        while (!done_seen && t < 400) begin
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = $urandom_range(0, 1);
                default: out_ready = (t % 3 == 0);
            endcase
            if (inject == 1) start = (t == 2);
            if (inject == 1 && t == 2) begin
                w_base = 3'd5; a_base = 3'd5; burst_len = 8'd7; a_mode = 2'b11; w_mode = 2'b11;
            end
            if (inject == 2 && t == 2) begin
                wen = 1; w_write_address = 3'd2; a_write_address = 3'd2;
                w_in = {DATA_W/32{32'hdead_beef}}; a_in = {DATA_W/32{32'hcafe_f00d}};
            end
            if (inject == 2 && t == 3) begin
                wen = 0; wmem[2] = w_in; amem[2] = a_in;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 0;
        out_ready = 1;
        chk_bit("burst_timeout", done_seen, 1'b1);
        chk_int("beats_left", exp_q.size(), 0);
        chk_int("beats_accepted", acc_cnt, n);
        chk_bit("busy_after", busy, 1'b0);
`ifdef DISPATCH_PERF_CNT_EN
        chk_int("stall_cycles", int'(stall_cycles), stall_cnt);
        chk_int("beats_sent", int'(beats_sent), n);
`endif
        exp_q.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] cw;
        int t;
        rst_n = 0; wen = 0; start = 0; out_ready = 1;
        w_write_address = '0; a_write_address = '0; w_in = '0; a_in = '0;
        w_base = '0; a_base = '0; burst_len = '0; a_mode = '0; w_mode = '0;
        for (int i = 0; i < DEPTH; i++) begin wmem[i] = '0; amem[i] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bit("rst_empty", empty, 1'b1);
        chk_bit("rst_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_word("rst_act", activations, '0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(i), DATA_W'(100 + i));
        chk_bit("empty_after_write", empty, 1'b0);

        do_burst(0, 0, 4, 2'b00, 2'b00, 0, 0);
        do_burst(6, 6, 4, 2'b00, 2'b00, 0, 0);

        cw = '0;
        for (int k = 0; k < G * G; k++) cw[k*CW +: CW] = CW'(k + 1);
        wr(3, cw, cw);
        do_burst(3, 3, 1, 2'b01, 2'b11, 0, 0);
        do_burst(3, 3, 1, 2'b11, 2'b10, 0, 0);
        do_burst(3, 3, 1, 2'b10, 2'b01, 0, 0);

        do_burst(0, 0, 6, 2'b00, 2'b00, 2, 0);
        do_burst(4, 1, 0, 2'b00, 2'b00, 0, 0);
        do_burst(0, 0, 4, 2'b00, 2'b00, 0, 1);
        do_burst(0, 0, 4, 2'b00, 2'b00, 0, 2);
        do_burst(2, 2, 1, 2'b00, 2'b00, 0, 0);

        // Reset in the middle of a 5-beat burst.
        push_exp(0, 0, 5, 2'b00, 2'b00);
        launch(0, 0, 5, 2'b00, 2'b00);
        t = 0;
        while (acc_cnt < 2 && t < 50) begin @(posedge clk); #1; t++; end
        chk_bit("mid_reset_reach", acc_cnt >= 2, 1'b1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk_bit("ar_valid", out_valid, 1'b0);
        chk_bit("ar_last", out_last, 1'b0);
        chk_bit("ar_busy", busy, 1'b0);
        chk_bit("ar_empty", empty, 1'b1);
        chk_word("ar_act", activations, '0);
        chk_word("ar_w", weight_columns, '0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin wmem[i] = '0; amem[i] = '0; end
        repeat (3) begin @(negedge clk); chk_bit("ar_done", done, 1'b0); end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk_bit("ar_done_after", done, 1'b0);
        do_burst(5, 1, 3, 2'b00, 2'b00, 0, 0);
        wr(5, rnd_word(), rnd_word());
        do_burst(4, 4, 3, 2'b01, 2'b10, 1, 0);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) wr($urandom_range(0, DEPTH - 1), rnd_word(), rnd_word());
            do_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 12),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
